i2c_master_latin: RTL and testbench

Single-byte I2C controller (bus master) that issues one START/address/data/STOP transaction per accepted command and reports the read data and acknowledge status. Sits on the user side of the chip's I/O ring, driving SCL and SDA through bidirectional pads with separate output and output-enable signals, and is the initiator counterpart to the design's I2C slave block.

---
 rtl/i2c_master_latin.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_i2c_master_latin.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_latin.sv
// ---------------------------------------------------------------------------
// i2c_master_latin
//
// Single-byte I2C bus master. Each accepted command produces one
// START / address+rw / data byte / STOP transaction on an open-drain bus
// and reports the read byte and the acknowledge status.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake; accepted when both are high
//   cmd_rw                  0 = write, 1 = read
//   cmd_addr [6:0]          7-bit target address
//   cmd_wdata[7:0]          byte to write
//   rdata[7:0]              byte read from the target (MSB first on the bus)
//   done                    one-cycle pulse when a transaction ends
//   ack_err                 a NACK was seen; valid with done
//   busy                    inverse of cmd_ready
//   scl_in                  reserved (no clock stretching)
//   scl_out/scl_oe          SCL pad; oe=1 pulls the line low
//   sda_in                  SDA pad input
//   sda_out/sda_oe          SDA pad; oe=1 pulls the line low
//
// CLK_DIV is the number of clk cycles per SCL quarter period and must be
// at least 4, because the SDA synchronizer adds two cycles of lag ahead of
// the sampling tick.
// ---------------------------------------------------------------------------
module i2c_master_latin #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic [7:0] rdata,
    output logic       done,
    output logic       ack_err,
    output logic       busy,
    input  logic       scl_in,
    output logic       scl_out,
    output logic       scl_oe,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WACK,
        S_READ,
        S_RNACK,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_divCnt;
    logic [1:0]       r_quarter;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_txShift;
    logic [7:0]       r_wdata;
    logic             r_rw;
    logic [7:0]       r_rdata;
    logic             r_ackErr;
    logic             r_done;
    logic             r_sclOe;
    logic             r_sdaOe;
    logic             r_sdaMeta;
    logic             r_sdaSync;

    state_t           w_stateNext;
    logic [1:0]       w_quarterNext;
    logic [2:0]       w_bitNext;
    logic [7:0]       w_txNext;
    logic [7:0]       w_wdataNext;
    logic             w_rwNext;
    logic [7:0]       w_rdataNext;
    logic             w_ackErrNext;
    logic             w_doneNext;
    logic             w_sclOeNext;
    logic             w_sdaOeNext;

    logic             w_accept;
    logic             w_tick;
    logic             w_isBitState;
    logic             w_unusedSclIn;

    // Clock stretching is not supported, so the SCL input is not observed.
    assign w_unusedSclIn = scl_in;

    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_tick       = (r_state != S_IDLE) && (r_divCnt == DIV_W'(CLK_DIV - 1));
    // Every state that moves one bit over nine or eight SCL pulses shares
    // the same SCL shape: low for q0/q1, released for q2/q3.
    assign w_isBitState = (r_state == S_ADDR)  || (r_state == S_ADDR_ACK) ||
                          (r_state == S_WRITE) || (r_state == S_WACK)     ||
                          (r_state == S_READ)  || (r_state == S_RNACK);

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rdata     = r_rdata;
    assign done      = r_done;
    assign ack_err   = r_ackErr;
    assign scl_out   = 1'b0;
    assign sda_out   = 1'b0;
    assign scl_oe    = r_sclOe;
    assign sda_oe    = r_sdaOe;

    // Quarter-period divider: restarts at acceptance so tick N lands exactly
    // N*CLK_DIV cycles after the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_divCnt <= '0;
        end else if (w_accept || (r_state == S_IDLE) || w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Two-flop synchronizer for the SDA pad; idle line reads as released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sdaMeta <= 1'b1;
            r_sdaSync <= 1'b1;
        end else begin
            r_sdaMeta <= sda_in;
            r_sdaSync <= r_sdaMeta;
        end
    end

    // State and datapath registers. Pad enables are registered so the bus
    // only changes on quarter ticks and never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_quarter <= 2'd0;
            r_bitCnt  <= 3'd0;
            r_txShift <= 8'h00;
            r_wdata   <= 8'h00;
            r_rw      <= 1'b0;
            r_rdata   <= 8'h00;
            r_ackErr  <= 1'b0;
            r_done    <= 1'b0;
            r_sclOe   <= 1'b0;
            r_sdaOe   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_quarter <= w_quarterNext;
            r_bitCnt  <= w_bitNext;
            r_txShift <= w_txNext;
            r_wdata   <= w_wdataNext;
            r_rw      <= w_rwNext;
            r_rdata   <= w_rdataNext;
            r_ackErr  <= w_ackErrNext;
            r_done    <= w_doneNext;
            r_sclOe   <= w_sclOeNext;
            r_sdaOe   <= w_sdaOeNext;
        end
    end

    // Next-state and bus sequencing. Outside IDLE everything advances only
    // on a quarter tick; r_quarter wraps from 3 to 0 at each bit boundary.
    always_comb begin
        w_stateNext   = r_state;
        w_quarterNext = r_quarter;
        w_bitNext     = r_bitCnt;
        w_txNext      = r_txShift;
        w_wdataNext   = r_wdata;
        w_rwNext      = r_rw;
        w_rdataNext   = r_rdata;
        w_ackErrNext  = r_ackErr;
        w_doneNext    = 1'b0;
        w_sclOeNext   = r_sclOe;
        w_sdaOeNext   = r_sdaOe;

        if (r_state == S_IDLE) begin
            if (cmd_valid) begin
                // START begins right away: SDA falls while SCL is still high.
                w_stateNext   = S_START;
                w_quarterNext = 2'd0;
                w_bitNext     = 3'd0;
                w_txNext      = {cmd_addr, cmd_rw};
                w_wdataNext   = cmd_wdata;
                w_rwNext      = cmd_rw;
                w_ackErrNext  = 1'b0;
                w_sclOeNext   = 1'b0;
                w_sdaOeNext   = 1'b1;
            end
        end else if (w_tick) begin
            w_quarterNext = r_quarter + 2'd1;

            if (w_isBitState) begin
                if (r_quarter == 2'd1) begin
                    w_sclOeNext = 1'b0;
                end
                if (r_quarter == 2'd3) begin
                    w_sclOeNext = 1'b1;
                end
            end

            case (r_state)
                S_START: begin
                    if (r_quarter == 2'd1) begin
                        w_sclOeNext = 1'b1;
                    end
                    if (r_quarter == 2'd2) begin
                        w_stateNext   = S_ADDR;
                        w_quarterNext = 2'd0;
                        w_bitNext     = 3'd0;
                        w_sdaOeNext   = ~r_txShift[7];
                    end
                end

                S_ADDR, S_WRITE: begin
                    if (r_quarter == 2'd3) begin
                        if (r_bitCnt == 3'd7) begin
                            w_stateNext = (r_state == S_ADDR) ? S_ADDR_ACK : S_WACK;
                            w_bitNext   = 3'd0;
                            w_sdaOeNext = 1'b0;
                        end else begin
                            w_bitNext   = r_bitCnt + 3'd1;
                            w_txNext    = {r_txShift[6:0], 1'b0};
                            w_sdaOeNext = ~r_txShift[6];
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if ((r_quarter == 2'd2) && r_sdaSync) begin
                        w_ackErrNext = 1'b1;
                    end
                    // ack_err can only have been set by this ACK slot, so it
                    // doubles as the address-NACK flag here.
                    if (r_quarter == 2'd3) begin
                        w_bitNext = 3'd0;
                        if (r_ackErr) begin
                            w_stateNext = S_STOP;
                            w_sdaOeNext = 1'b1;
                        end else if (r_rw) begin
                            w_stateNext = S_READ;
                            w_sdaOeNext = 1'b0;
                        end else begin
                            w_stateNext = S_WRITE;
                            w_txNext    = r_wdata;
                            w_sdaOeNext = ~r_wdata[7];
                        end
                    end
                end

                S_WACK: begin
                    if ((r_quarter == 2'd2) && r_sdaSync) begin
                        w_ackErrNext = 1'b1;
                    end
                    if (r_quarter == 2'd3) begin
                        w_stateNext = S_STOP;
                        w_sdaOeNext = 1'b1;
                    end
                end

                S_READ: begin
                    if (r_quarter == 2'd2) begin
                        w_rdataNext = {r_rdata[6:0], r_sdaSync};
                    end
                    if (r_quarter == 2'd3) begin
                        if (r_bitCnt == 3'd7) begin
                            w_stateNext = S_RNACK;
                            w_bitNext   = 3'd0;
                        end else begin
                            w_bitNext = r_bitCnt + 3'd1;
                        end
                    end
                end

                S_RNACK: begin
                    if (r_quarter == 2'd3) begin
                        w_stateNext = S_STOP;
                        w_sdaOeNext = 1'b1;
                    end
                end

                S_STOP: begin
                    // q0 both low, q1 SCL released, q2 SDA released, q3 bus free.
                    if (r_quarter == 2'd0) begin
                        w_sclOeNext = 1'b0;
                    end
                    if (r_quarter == 2'd1) begin
                        w_sdaOeNext = 1'b0;
                    end
                    if (r_quarter == 2'd3) begin
                        w_stateNext = S_IDLE;
                        w_doneNext  = 1'b1;
                    end
                end

                default: begin
                    w_stateNext = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_latin.sv
// ---------------------------------------------------------------------------
// tb_i2c_master_latin
//
// Directed bench for i2c_master_latin. Instance A (CLK_DIV=4) talks to a
// behavioural slave that oversamples the bus on the falling system clock;
// instance B (CLK_DIV=8) has no slave and is used for divider timing and
// back-to-back acceptance. Expected done timing, rdata and ack_err are
// queued when a command is issued and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_i2c_master_latin;

    typedef struct {
        int         cycles;
        logic [7:0] rdata;
        logic       ackErr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       cmdValid, cmdRw, cmdReady, done, ackErr, busy;
    logic [6:0] cmdAddr;
    logic [7:0] cmdWdata, rdata;
    logic       sclOut, sclOe, sdaOut, sdaOe, sdaIn;

    logic       cmdValidB, cmdRwB, cmdReadyB, doneB, ackErrB, busyB;
    logic [6:0] cmdAddrB;
    logic [7:0] cmdWdataB, rdataB;
    logic       sclOutB, sclOeB, sdaOutB, sdaOeB, sdaInB;

    logic slvPull = 1'b0;
    wire  sclLine = ~sclOe;
    wire  sdaLine = ~(sdaOe | slvPull);
    wire  sclLineB = ~sclOeB;
    assign sdaIn  = sdaLine;
    assign sdaInB = ~sdaOeB;

    int   checks = 0;
    int   failures = 0;
    exp_t sbQ[$];
    int   runs[$];

    i2c_master_latin #(.CLK_DIV(4)) dutA (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_rw(cmdRw),
        .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata),
        .rdata(rdata), .done(done), .ack_err(ackErr), .busy(busy),
        .scl_in(sclLine), .scl_out(sclOut), .scl_oe(sclOe),
        .sda_in(sdaIn), .sda_out(sdaOut), .sda_oe(sdaOe)
    );

    i2c_master_latin #(.CLK_DIV(8)) dutB (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB), .cmd_rw(cmdRwB),
        .cmd_addr(cmdAddrB), .cmd_wdata(cmdWdataB),
        .rdata(rdataB), .done(doneB), .ack_err(ackErrB), .busy(busyB),
        .scl_in(sclLineB), .scl_out(sclOutB), .scl_oe(sclOeB),
        .sda_in(sdaInB), .sda_out(sdaOutB), .sda_oe(sdaOeB)
    );

    // Behavioural slave: detects START/STOP, logs every bit seen on an SCL
    // rise, and drives ACK or read data after SCL falls.
    logic [6:0] slvAddr = 7'h2A;
    logic       slvAckData = 1'b1;
    logic [7:0] slvReadByte = 8'h00;
    logic [7:0] slvShift = 8'h00;
    logic       slvMatch = 1'b0, slvRead = 1'b0, slvActive = 1'b0;
    logic       prevScl = 1'b1, prevSda = 1'b1;
    int         slvBit = 0, slvByte = 0, startCnt = 0, stopCnt = 0, sclRises = 0;
    logic       busQ[$];

    always @(negedge clk) begin
        if (prevScl && sclLine && prevSda && !sdaLine) begin
            slvActive = 1'b1;
            slvBit = 0;
            slvByte = 0;
            slvMatch = 1'b0;
            slvRead = 1'b0;
            slvPull = 1'b0;
            sclRises = 0;
            busQ.delete();
            startCnt++;
        end else if (prevScl && sclLine && !prevSda && sdaLine) begin
            slvActive = 1'b0;
            slvPull = 1'b0;
            stopCnt++;
        end else if (slvActive && !prevScl && sclLine) begin
            sclRises++;
            busQ.push_back(sdaLine);
            if (slvBit < 8) slvShift = {slvShift[6:0], sdaLine};
            if (slvByte == 0 && slvBit == 7) begin
                slvMatch = (slvShift[7:1] == slvAddr);
                slvRead = slvShift[0];
            end
            slvBit++;
            if (slvBit == 9) begin
                slvBit = 0;
                slvByte++;
            end
        end else if (slvActive && prevScl && !sclLine) begin
            slvPull = 1'b0;
            if (slvByte == 0 && slvBit == 8) begin
                slvPull = slvMatch;
            end else if (slvByte == 1 && slvMatch) begin
                if (slvRead) begin
                    if (slvBit < 8) slvPull = ~slvReadByte[7 - slvBit];
                end else if (slvBit == 8) begin
                    slvPull = slvAckData;
                end
            end
        end
        prevScl = sclLine;
        prevSda = sdaLine;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one command into instance A and queues its expected outcome.
    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                                 input bit pushExp, input int expCycles,
                                 input logic [7:0] expRdata, input logic expAck);
        exp_t e;
        @(negedge clk);
        checkOutput("ready_before_cmd", cmdReady, 1);
        cmdValid = 1'b1;
        cmdRw = rw;
        cmdAddr = addr;
        cmdWdata = wdata;
        if (pushExp) begin
            e.cycles = expCycles;
            e.rdata = expRdata;
            e.ackErr = expAck;
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
    endtask

    // Counts clk edges after acceptance until done is seen, bounded.
    task automatic waitDone(input bit useB, output int cyc);
        logic prevOe;
        int   lastChange;
        cyc = 0;
        lastChange = 0;
        prevOe = sclOeB;
        runs.delete();
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (useB && (sclOeB !== prevOe)) begin
                runs.push_back(cyc - lastChange);
                lastChange = cyc;
                prevOe = sclOeB;
            end
            if ((useB ? doneB : done) === 1'b1) break;
        end
    endtask

    task automatic checkDone(input bit useB, input int cyc);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sbQ.pop_front();
            checkOutput("done_cycle", cyc, e.cycles);
            checkOutput("rdata", useB ? rdataB : rdata, {24'h0, e.rdata});
            checkOutput("ack_err", useB ? ackErrB : ackErr, {31'h0, e.ackErr});
            checkOutput("ready_with_done", useB ? cmdReadyB : cmdReady, 1);
        end
    endtask

    task automatic checkBus(input string tag, input int n, input logic [17:0] expVec);
        logic [17:0] act;
        act = '0;
        for (int i = 0; i < n; i++) begin
            act = {act[16:0], (i < busQ.size()) ? busQ[i] : 1'bx};
        end
        checkOutput(tag, {14'h0, act}, {14'h0, expVec});
    endtask

    initial begin
        int cyc;
        int stopsBefore;

        rst_n = 1'b0;
        cmdValid = 1'b0; cmdRw = 1'b0; cmdAddr = '0; cmdWdata = '0;
        cmdValidB = 1'b0; cmdRwB = 1'b0; cmdAddrB = '0; cmdWdataB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_scl_oe", sclOe, 0);
        checkOutput("rst_sda_oe", sdaOe, 0);
        checkOutput("rst_scl_out", sclOut, 0);
        checkOutput("rst_sda_out", sdaOut, 0);
        checkOutput("rst_cmd_ready", cmdReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ack_err", ackErr, 0);
        checkOutput("rst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] write 0x2A <- 0xA5");
        stopsBefore = stopCnt;
        applyStimulus(1'b0, 7'h2A, 8'hA5, 1, 316, 8'h00, 1'b0);
        waitDone(0, cyc);
        checkDone(0, cyc);
        checkBus("write_bus", 18, 18'b0101010_0_0_10100101_0);
        checkOutput("write_scl_pulses", sclRises, 19);
        checkOutput("write_stop", stopCnt, stopsBefore + 1);

        $display("[TB] read 0x2A -> 0x3C");
        slvReadByte = 8'h3C;
        applyStimulus(1'b1, 7'h2A, 8'h00, 1, 316, 8'h3C, 1'b0);
        waitDone(0, cyc);
        checkDone(0, cyc);
        checkBus("read_bus", 18, 18'b0101010_1_0_00111100_1);

        $display("[TB] address NACK 0x11");
        stopsBefore = stopCnt;
        applyStimulus(1'b0, 7'h11, 8'h55, 1, 172, 8'h3C, 1'b1);
        waitDone(0, cyc);
        checkDone(0, cyc);
        checkBus("nack_addr_bus", 9, 18'b0010001_0_1);
        checkOutput("nack_scl_pulses", sclRises, 10);
        checkOutput("nack_stop", stopCnt, stopsBefore + 1);

        $display("[TB] write-data NACK");
        slvAckData = 1'b0;
        stopsBefore = stopCnt;
        applyStimulus(1'b0, 7'h2A, 8'h0F, 1, 316, 8'h3C, 1'b1);
        waitDone(0, cyc);
        checkDone(0, cyc);
        checkBus("nack_data_bus", 18, 18'b0101010_0_0_00001111_1);
        checkOutput("nack_data_stop", stopCnt, stopsBefore + 1);
        slvAckData = 1'b1;
        applyStimulus(1'b0, 7'h2A, 8'hC3, 1, 316, 8'h3C, 1'b0);
        checkOutput("ack_err_cleared", ackErr, 0);
        waitDone(0, cyc);
        checkDone(0, cyc);

        $display("[TB] reset during address phase");
        applyStimulus(1'b0, 7'h2A, 8'h77, 0, 0, 8'h00, 1'b0);
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_scl_oe", sclOe, 0);
        checkOutput("midrst_sda_oe", sdaOe, 0);
        checkOutput("midrst_cmd_ready", cmdReady, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_rdata", rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 7'h2A, 8'h5A, 1, 316, 8'h00, 1'b0);
        waitDone(0, cyc);
        checkDone(0, cyc);
        checkBus("postrst_bus", 18, 18'b0101010_0_0_01011010_0);

        $display("[TB] back-to-back on CLK_DIV=8");
        @(negedge clk);
        cmdValidB = 1'b1;
        cmdRwB = 1'b0;
        cmdAddrB = 7'h55;
        cmdWdataB = 8'h00;
        sbQ.push_back('{cycles: 344, rdata: 8'h00, ackErr: 1'b1});
        sbQ.push_back('{cycles: 344, rdata: 8'h00, ackErr: 1'b1});
        @(posedge clk);
        #1;
        checkOutput("b2b_busy_first", busyB, 1);
        waitDone(1, cyc);
        checkDone(1, cyc);
        checkOutput("scl_high_phase", (runs.size() > 2) ? runs[2] : -1, 16);
        checkOutput("scl_low_phase", (runs.size() > 3) ? runs[3] : -1, 16);
        @(posedge clk);
        #1;
        checkOutput("b2b_second_accept", busyB, 1);
        checkOutput("b2b_done_cleared", doneB, 0);
        cmdValidB = 1'b0;
        waitDone(1, cyc);
        checkDone(1, cyc);
        @(negedge clk);
        checkOutput("b2b_idle_after", busyB, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
